// File: rtl/rs_ua_issue_if.sv
// rs_ua_issue_if: issue, CDB-snoop and UA dispatch signals of the add/sub/address reservation station.
interface rs_ua_issue_if;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [2:0]  issue_rd;
    logic [15:0] issue_vj;
    logic [15:0] issue_vk;
    logic [3:0]  issue_qj;
    logic [3:0]  issue_qk;
    logic        issue_ready;
    logic [3:0]  issue_id;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        ua_busy;
    logic        ua_confirm;
    logic        ua_start;
    logic [3:0]  ua_id;
    logic [15:0] ua_dado1;
    logic [15:0] ua_dado2;
    logic [5:0]  ua_op_rd;
    logic [3:0]  rs_count;
    modport master (
        output issue_valid, issue_op, issue_rd, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data, ua_busy, ua_confirm,
        input  issue_ready, issue_id, ua_start, ua_id, ua_dado1, ua_dado2, ua_op_rd, rs_count
    );
    modport slave (
        input  issue_valid, issue_op, issue_rd, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data, ua_busy, ua_confirm,
        output issue_ready, issue_id, ua_start, ua_id, ua_dado1, ua_dado2, ua_op_rd, rs_count
    );
endinterface

// File: rtl/rs_ua_issue.sv
// rs_ua_issue: reservation-station bank dispatching ready entries to the add/sub/address unit.
// RS_AGE_PRIORITY_EN selects the oldest ready entry instead of the lowest-index one.
module rs_ua_issue #(
    parameter int         N_ENT   = 3,
    parameter logic [3:0] ID_BASE = 4'd1
) (
    input logic          CLK,
    input logic          CLR,
    rs_ua_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT_CONF, WAIT_DONE} state_t;
    state_t state_q, state_d;
    logic [N_ENT-1:0] valid_q, inflight_q;
    logic [2:0] op_q [N_ENT];
    logic [2:0] rd_q [N_ENT];
    logic [15:0] vj_q [N_ENT];
    logic [15:0] vk_q [N_ENT];
    logic [3:0] qj_q [N_ENT];
    logic [3:0] qk_q [N_ENT];
    logic [2:0] free_idx, sel_idx, disp_idx_q;
    logic [3:0] sel_id, disp_id_q, cnt;
    logic [15:0] sel_vj, sel_vk, disp_vj_q, disp_vk_q;
    logic [5:0] sel_oprd, disp_oprd_q;
    logic free_any, sel_any, cdb_hit, issue_fire, dispatch, confirm;
`ifdef RS_AGE_PRIORITY_EN
    logic [3:0] age_q [N_ENT];
    logic [3:0] sel_age;
`endif
    assign cdb_hit    = bus.cdb_valid && bus.cdb_tag != 4'd0;
    assign issue_fire = bus.issue_valid && free_any;
    assign dispatch   = state_q == IDLE && sel_any && !bus.ua_busy;
    assign confirm    = state_q == WAIT_CONF && bus.ua_confirm;
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        cnt = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            cnt = cnt + 4'(valid_q[i]);
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
        end
    end
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        sel_id = '0;
        sel_vj = '0;
        sel_vk = '0;
        sel_oprd = '0;
`ifdef RS_AGE_PRIORITY_EN
        sel_age = '0;
`endif
        for (int i = 0; i < N_ENT; i++) begin
`ifdef RS_AGE_PRIORITY_EN
            if (valid_q[i] && !inflight_q[i] && qj_q[i] == 4'd0 && qk_q[i] == 4'd0 && (!sel_any || age_q[i] > sel_age)) begin
                sel_age = age_q[i];
`else
            if (valid_q[i] && !inflight_q[i] && qj_q[i] == 4'd0 && qk_q[i] == 4'd0 && !sel_any) begin
`endif
                sel_any = 1'b1;
                sel_idx = 3'(i);
                sel_id = ID_BASE + 4'(i);
                sel_vj = vj_q[i];
                sel_vk = vk_q[i];
                sel_oprd = {rd_q[i], op_q[i]};
            end
        end
    end
    // an issued tag matching this cycle's broadcast is captured immediately
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            valid_q <= '0;
            inflight_q <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                op_q[i] <= '0;
                rd_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                if (issue_fire && free_idx == 3'(i)) begin
                    valid_q[i] <= 1'b1;
                    inflight_q[i] <= 1'b0;
                    op_q[i] <= bus.issue_op;
                    rd_q[i] <= bus.issue_rd;
                    vj_q[i] <= cdb_hit && bus.issue_qj == bus.cdb_tag ? bus.cdb_data : bus.issue_vj;
                    qj_q[i] <= cdb_hit && bus.issue_qj == bus.cdb_tag ? 4'd0 : bus.issue_qj;
                    vk_q[i] <= cdb_hit && bus.issue_qk == bus.cdb_tag ? bus.cdb_data : bus.issue_vk;
                    qk_q[i] <= cdb_hit && bus.issue_qk == bus.cdb_tag ? 4'd0 : bus.issue_qk;
                end else begin
                    if (confirm && disp_idx_q == 3'(i)) begin
                        valid_q[i] <= 1'b0;
                        inflight_q[i] <= 1'b0;
                    end else if (dispatch && sel_idx == 3'(i)) begin
                        inflight_q[i] <= 1'b1;
                    end
                    if (valid_q[i] && cdb_hit && qj_q[i] == bus.cdb_tag) begin
                        vj_q[i] <= bus.cdb_data;
                        qj_q[i] <= 4'd0;
                    end
                    if (valid_q[i] && cdb_hit && qk_q[i] == bus.cdb_tag) begin
                        vk_q[i] <= bus.cdb_data;
                        qk_q[i] <= 4'd0;
                    end
                end
            end
        end
    end
`ifdef RS_AGE_PRIORITY_EN
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < N_ENT; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++)
                age_q[i] <= issue_fire && free_idx == 3'(i) ? 4'd0 :
                            valid_q[i] && age_q[i] != 4'd15 ? age_q[i] + 4'd1 : age_q[i];
        end
    end
`endif
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            disp_idx_q <= '0;
            disp_id_q <= '0;
            disp_vj_q <= '0;
            disp_vk_q <= '0;
            disp_oprd_q <= '0;
        end else begin
            state_q <= state_d;
            if (dispatch) begin
                disp_idx_q <= sel_idx;
                disp_id_q <= sel_id;
                disp_vj_q <= sel_vj;
                disp_vk_q <= sel_vk;
                disp_oprd_q <= sel_oprd;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = dispatch ? START : IDLE;
            START:     state_d = WAIT_CONF;
            WAIT_CONF: state_d = bus.ua_confirm ? WAIT_DONE : WAIT_CONF;
            WAIT_DONE: state_d = bus.ua_busy ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.ua_start = state_q == START;
        bus.ua_id = disp_id_q;
        bus.ua_dado1 = disp_vj_q;
        bus.ua_dado2 = disp_vk_q;
        bus.ua_op_rd = disp_oprd_q;
        bus.issue_ready = free_any;
        bus.issue_id = ID_BASE + {1'b0, free_idx};
        bus.rs_count = cnt;
    end
endmodule

// File: tb/tb_rs_ua_issue.sv
// tb_rs_ua_issue: directed self-checking bench for rs_ua_issue.
module tb_rs_ua_issue;
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    rs_ua_issue_if b ();
    rs_ua_issue #(.N_ENT(3), .ID_BASE(4'd1)) dut (.CLK(CLK), .CLR(CLR), .bus(b));
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [15:0] vj,
                         input logic [15:0] vk, input logic [3:0] qj, input logic [3:0] qk);
        b.issue_valid = 1'b1;
        b.issue_op = op;
        b.issue_rd = rd;
        b.issue_vj = vj;
        b.issue_vk = vk;
        b.issue_qj = qj;
        b.issue_qk = qk;
        tick();
        b.issue_valid = 1'b0;
    endtask
    task automatic bcast(input logic [3:0] tag, input logic [15:0] data);
        b.cdb_valid = 1'b1;
        b.cdb_tag = tag;
        b.cdb_data = data;
        tick();
        b.cdb_valid = 1'b0;
    endtask
    task automatic wait_start(input string tag);
        int n = 0;
        while (!b.ua_start && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(b.ua_start), 32'd1);
    endtask
    task automatic confirm_op();
        tick();
        b.ua_confirm = 1'b1;
        tick();
        b.ua_confirm = 1'b0;
        tick();
    endtask
    task automatic no_start(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | b.ua_start;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask
    initial begin
        b.issue_valid = 1'b0;
        b.issue_op = '0;
        b.issue_rd = '0;
        b.issue_vj = '0;
        b.issue_vk = '0;
        b.issue_qj = '0;
        b.issue_qk = '0;
        b.cdb_valid = 1'b0;
        b.cdb_tag = '0;
        b.cdb_data = '0;
        b.ua_busy = 1'b0;
        b.ua_confirm = 1'b0;
        tick();
        tick();
        chk("rst_start", 32'(b.ua_start), 32'd0);
        chk("rst_count", 32'(b.rs_count), 32'd0);
        chk("rst_ready", 32'(b.issue_ready), 32'd1);
        chk("rst_issue_id", 32'(b.issue_id), 32'd1);
        chk("rst_ua_id", 32'(b.ua_id), 32'd0);
        chk("rst_dado1", 32'(b.ua_dado1), 32'd0);
        chk("rst_op_rd", 32'(b.ua_op_rd), 32'd0);
        CLR = 1'b1;
        tick();
        // basic add, earliest dispatch
        issue(3'b001, 3'd2, 16'd5, 16'd7, 4'd0, 4'd0);
        chk("add_count", 32'(b.rs_count), 32'd1);
        chk("add_next_id", 32'(b.issue_id), 32'd2);
        chk("add_not_yet", 32'(b.ua_start), 32'd0);
        tick();
        chk("add_start", 32'(b.ua_start), 32'd1);
        chk("add_op_rd", 32'(b.ua_op_rd), 32'b010001);
        chk("add_dado1", 32'(b.ua_dado1), 32'd5);
        chk("add_dado2", 32'(b.ua_dado2), 32'd7);
        chk("add_id", 32'(b.ua_id), 32'd1);
        tick();
        chk("add_pulse_end", 32'(b.ua_start), 32'd0);
        chk("add_hold", 32'(b.ua_dado1), 32'd5);
        b.ua_confirm = 1'b1;
        tick();
        b.ua_confirm = 1'b0;
        chk("add_freed", 32'(b.rs_count), 32'd0);
        tick();
        // sub waiting on tag 2
        issue(3'b010, 3'd3, 16'd0, 16'd9, 4'd2, 4'd0);
        no_start("sub_blocked", 3);
        bcast(4'd2, 16'h0010);
        wait_start("sub_start");
        chk("sub_dado1", 32'(b.ua_dado1), 32'h0010);
        chk("sub_dado2", 32'(b.ua_dado2), 32'd9);
        chk("sub_op_rd", 32'(b.ua_op_rd), 32'b011010);
        confirm_op();
        // issue-cycle bypass
        b.cdb_valid = 1'b1;
        b.cdb_tag = 4'd3;
        b.cdb_data = 16'hBEEF;
        issue(3'b011, 3'd1, 16'h1111, 16'd0, 4'd0, 4'd3);
        b.cdb_valid = 1'b0;
        wait_start("byp_start");
        chk("byp_dado2", 32'(b.ua_dado2), 32'hBEEF);
        chk("byp_dado1", 32'(b.ua_dado1), 32'h1111);
        chk("byp_id", 32'(b.ua_id), 32'd1);
        confirm_op();
        // fill all entries
        issue(3'b001, 3'd1, 16'd0, 16'd1, 4'd5, 4'd0);
        issue(3'b001, 3'd2, 16'd0, 16'd2, 4'd5, 4'd0);
        issue(3'b001, 3'd3, 16'd0, 16'd3, 4'd5, 4'd0);
        chk("full_ready", 32'(b.issue_ready), 32'd0);
        chk("full_count", 32'(b.rs_count), 32'd3);
        issue(3'b100, 3'd4, 16'd4, 16'd4, 4'd0, 4'd0);
        chk("full_ignored", 32'(b.rs_count), 32'd3);
        no_start("full_no_start", 2);
        bcast(4'd5, 16'h0055);
        wait_start("full_start");
        chk("full_id0", 32'(b.ua_id), 32'd1);
        chk("full_dado1", 32'(b.ua_dado1), 32'h0055);
        tick();
        b.ua_confirm = 1'b1;
        chk("full_no_bypass", 32'(b.issue_ready), 32'd0);
        tick();
        b.ua_confirm = 1'b0;
        chk("full_reuse", 32'(b.issue_ready), 32'd1);
        chk("full_reuse_id", 32'(b.issue_id), 32'd1);
        chk("full_count2", 32'(b.rs_count), 32'd2);
        tick();
        wait_start("full_start2");
        chk("full_id1", 32'(b.ua_id), 32'd2);
        confirm_op();
        wait_start("full_start3");
        chk("full_id2", 32'(b.ua_id), 32'd3);
        chk("full_dado2", 32'(b.ua_dado2), 32'd3);
        confirm_op();
        chk("full_drained", 32'(b.rs_count), 32'd0);
        // entry 2 older than entry 0, both ready together
        issue(3'b001, 3'd0, 16'd0, 16'hA0, 4'd8, 4'd0);
        issue(3'b001, 3'd1, 16'd0, 16'hA1, 4'd7, 4'd0);
        issue(3'b010, 3'd2, 16'd0, 16'hA2, 4'd6, 4'd0);
        bcast(4'd8, 16'h0008);
        wait_start("age_pre_start");
        chk("age_pre_id", 32'(b.ua_id), 32'd1);
        confirm_op();
        issue(3'b011, 3'd3, 16'd0, 16'hB0, 4'd6, 4'd0);
        bcast(4'd6, 16'h0006);
        wait_start("age_first_start");
`ifdef RS_AGE_PRIORITY_EN
        chk("age_first_id", 32'(b.ua_id), 32'd3);
`else
        chk("age_first_id", 32'(b.ua_id), 32'd1);
`endif
        confirm_op();
        wait_start("age_second_start");
`ifdef RS_AGE_PRIORITY_EN
        chk("age_second_id", 32'(b.ua_id), 32'd1);
`else
        chk("age_second_id", 32'(b.ua_id), 32'd3);
`endif
        confirm_op();
        bcast(4'd7, 16'h0007);
        wait_start("age_third_start");
        chk("age_third_id", 32'(b.ua_id), 32'd2);
        chk("age_third_dado2", 32'(b.ua_dado2), 32'hA1);
        confirm_op();
        // reset while waiting for confirmation
        issue(3'b001, 3'd5, 16'h1234, 16'h5678, 4'd0, 4'd0);
        issue(3'b001, 3'd6, 16'd0, 16'd1, 4'd9, 4'd0);
        wait_start("clr_start");
        tick();
        CLR = 1'b0;
        #1;
        chk("clr_start_low", 32'(b.ua_start), 32'd0);
        chk("clr_count", 32'(b.rs_count), 32'd0);
        chk("clr_dado1", 32'(b.ua_dado1), 32'd0);
        chk("clr_id", 32'(b.ua_id), 32'd0);
        chk("clr_op_rd", 32'(b.ua_op_rd), 32'd0);
        tick();
        CLR = 1'b1;
        b.ua_confirm = 1'b1;
        tick();
        b.ua_confirm = 1'b0;
        chk("clr_confirm_ignored", 32'(b.rs_count), 32'd0);
        no_start("clr_idle", 3);
        issue(3'b010, 3'd7, 16'd3, 16'd4, 4'd0, 4'd0);
        wait_start("clr_restart");
        chk("clr_restart_id", 32'(b.ua_id), 32'd1);
        chk("clr_restart_op_rd", 32'(b.ua_op_rd), 32'b111010);
        confirm_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
